// File: rtl/sprite_mover.sv
// Sprite motion controller: fixed-rate stepping in a held direction, one queued
// pre-turn with a lifetime, per-direction collision blocking and a horizontal tunnel.
module sprite_mover #(
  parameter int unsigned COORD_W    = 9,
  parameter int unsigned INIT_X     = 200,
  parameter int unsigned INIT_Y     = 230,
  parameter int unsigned VELOCITY   = 1,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned PEND_STEPS = 8,
  parameter bit          TUNNEL_EN  = 1'b1,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 447
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         btn,
  input  logic [3:0]         collide,
  output logic [COORD_W-1:0] p_x,
  output logic [COORD_W-1:0] p_y,
  output logic [3:0]         dir,
  output logic [3:0]         pending,
  output logic               moving,
  output logic               step
);

  localparam int unsigned EXT_W  = COORD_W + 1;
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PEND_W = $clog2(PEND_STEPS + 1);

  localparam logic [EXT_W-1:0] VEL_E  = EXT_W'(VELOCITY);
  localparam logic [EXT_W-1:0] MAX_E  = {1'b0, {COORD_W{1'b1}}};
  localparam logic [EXT_W-1:0] XMIN_E = EXT_W'(X_MIN);
  localparam logic [EXT_W-1:0] XMAX_E = EXT_W'(X_MAX);

  // Direction bit positions within {L,U,R,D}
  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_BLOCKED
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    prescale;
  logic [PEND_W-1:0]   pend_cnt;

  logic                step_cycle;
  logic                btn_onehot;
  logic                take_pend;
  logic                dir_free;
  logic [3:0]          mv_dir;
  logic [EXT_W-1:0]    x_e;
  logic [EXT_W-1:0]    y_e;
  logic [COORD_W-1:0]  x_left;
  logic [COORD_W-1:0]  x_right;
  logic [COORD_W-1:0]  y_up;
  logic [COORD_W-1:0]  y_down;
  logic [COORD_W-1:0]  nx;
  logic [COORD_W-1:0]  ny;

  function automatic logic [COORD_W-1:0] sat_dec(input logic [EXT_W-1:0] c);
    return (c < VEL_E) ? '0 : COORD_W'(c - VEL_E);
  endfunction

  function automatic logic [COORD_W-1:0] sat_inc(input logic [EXT_W-1:0] c);
    logic [EXT_W-1:0] s;
    s = c + VEL_E;
    return (s > MAX_E) ? COORD_W'(MAX_E) : COORD_W'(s);
  endfunction

  assign moving = (state == S_MOVE);

  // Step decision and candidate next position for the direction being taken
  always_comb begin
    step_cycle = (prescale == CNT_W'(TICK_DIV - 1));
    btn_onehot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    take_pend  = (pending != 4'd0) && ((collide & pending) == 4'd0);
    dir_free   = (dir != 4'd0) && ((collide & dir) == 4'd0);
    mv_dir     = take_pend ? pending : dir;

    x_e     = {1'b0, p_x};
    y_e     = {1'b0, p_y};
    x_left  = (TUNNEL_EN && (x_e < XMIN_E + VEL_E)) ? COORD_W'(X_MAX) : sat_dec(x_e);
    x_right = (TUNNEL_EN && (x_e + VEL_E > XMAX_E)) ? COORD_W'(X_MIN) : sat_inc(x_e);
    y_up    = sat_dec(y_e);
    y_down  = sat_inc(y_e);

    nx = p_x;
    ny = p_y;
    case (mv_dir)
      DIR_L:   nx = x_left;
      DIR_U:   ny = y_up;
      DIR_R:   nx = x_right;
      DIR_D:   ny = y_down;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_x      <= COORD_W'(INIT_X);
      p_y      <= COORD_W'(INIT_Y);
      dir      <= 4'd0;
      pending  <= 4'd0;
      pend_cnt <= '0;
      prescale <= '0;
      step     <= 1'b0;
      state    <= S_IDLE;
    end else begin
      step     <= step_cycle;
      prescale <= step_cycle ? '0 : prescale + CNT_W'(1);

      if (step_cycle) begin
        if (take_pend) begin
          dir     <= pending;
          pending <= 4'd0;
          p_x     <= nx;
          p_y     <= ny;
          state   <= S_MOVE;
        end else begin
          if (dir_free) begin
            p_x   <= nx;
            p_y   <= ny;
            state <= S_MOVE;
          end else begin
            state <= (dir == 4'd0) ? S_IDLE : S_BLOCKED;
          end
          // A queued turn that keeps being refused expires after its lifetime
          if (pending != 4'd0) begin
            if (pend_cnt <= PEND_W'(1)) begin
              pending  <= 4'd0;
              pend_cnt <= '0;
            end else begin
              pend_cnt <= pend_cnt - PEND_W'(1);
            end
          end
        end
      end

      // A fresh button press overrides whatever the step logic did to the queue
      if (btn_onehot) begin
        if (btn == dir) begin
          pending <= 4'd0;
        end else begin
          pending  <= btn;
          pend_cnt <= PEND_W'(PEND_STEPS);
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with an expected-value queue popped at each check point.
module tb_sprite_mover;

  localparam int unsigned W = 9;
  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] U = 4'b0100;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] D = 4'b0001;

  typedef logic [2*W+8:0] vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   btn;
  logic [3:0]   collide;
  logic [W-1:0] p_x;
  logic [W-1:0] p_y;
  logic [3:0]   dir;
  logic [3:0]   pending;
  logic         moving;
  logic         step;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  sprite_mover dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .collide (collide),
    .p_x     (p_x),
    .p_y     (p_y),
    .dir     (dir),
    .pending (pending),
    .moving  (moving),
    .step    (step)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [3:0] d, input logic [3:0] p,
                      input logic m);
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    xv = W'(x);
    yv = W'(y);
    exp_q.push_back({xv, yv, d, p, m});
  endtask

  task automatic compare(input string tag);
    vec_t e;
    vec_t o;
    o = {p_x, p_y, dir, pending, moving};
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed x=%0d y=%0d dir=%b pend=%b mv=%b expected x=%0d y=%0d dir=%b pend=%b mv=%b",
             tag, o[2*W+8 -: W], o[W+8 -: W], o[8:5], o[4:1], o[0],
             e[2*W+8 -: W], e[W+8 -: W], e[8:5], e[4:1], e[0]);
    end
  endtask

  task automatic check_eq(input string tag, input int o, input int e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Advance until the step pulse is seen; gap is the number of clocks taken
  task automatic wait_step(input string tag, output int gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < 20);
    gap = n;
    if (!step) begin
      n_vec++;
      n_err++;
      $error("FAIL step_timeout %s: observed no step in %0d clocks expected a step", tag, n);
    end
  endtask

  initial begin
    int  g;
    bit  changed;

    rst     = 1'b1;
    btn     = 4'd0;
    collide = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    push(200, 230, 4'd0, 4'd0, 1'b0);
    compare("reset");
    check_eq("reset_step", int'(step), 0);

    // Idle for 40 clocks with no buttons
    changed = 1'b0;
    repeat (40) begin
      tick();
      if (p_x !== W'(200) || p_y !== W'(230)) changed = 1'b1;
    end
    check_eq("idle_hold", int'(changed), 0);
    push(200, 230, 4'd0, 4'd0, 1'b0);
    compare("idle_state");

    // Continuous motion to the right after a one-clock press
    wait_step("align", g);
    btn = R;
    tick();
    btn = 4'd0;
    push(200, 230, 4'd0, R, 1'b0);
    compare("capture_R");
    wait_step("right1", g);
    push(201, 230, R, 4'd0, 1'b1);
    compare("right1");
    for (int k = 2; k <= 3; k++) begin
      wait_step("right", g);
      check_eq("step_gap", g, 4);
      push(200 + k, 230, R, 4'd0, 1'b1);
      compare("right_n");
    end

    // Pre-turn held off by a wall above, taken once it clears
    collide = U;
    btn     = U;
    tick();
    btn = 4'd0;
    push(203, 230, R, U, 1'b1);
    compare("preturn_cap");
    wait_step("preturn1", g);
    push(204, 230, R, U, 1'b1);
    compare("preturn1");
    wait_step("preturn2", g);
    push(205, 230, R, U, 1'b1);
    compare("preturn2");
    collide = 4'd0;
    wait_step("preturn3", g);
    push(205, 229, U, 4'd0, 1'b1);
    compare("preturn_taken");

    // Queued turn expires after eight refused steps
    btn = R;
    tick();
    btn = 4'd0;
    wait_step("back_right", g);
    push(206, 229, R, 4'd0, 1'b1);
    compare("back_right");
    collide = U;
    btn     = U;
    tick();
    btn = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      wait_step("pend_timeout", g);
      push(206 + k, 229, R, (k < 8) ? U : 4'd0, 1'b1);
      compare("pend_timeout");
    end
    collide = 4'd0;

    // Reversal, then a wall on the left, then resume
    btn = L;
    tick();
    btn = 4'd0;
    wait_step("reverse", g);
    push(213, 229, L, 4'd0, 1'b1);
    compare("reverse");
    collide = L;
    for (int k = 0; k < 2; k++) begin
      wait_step("blocked", g);
      push(213, 229, L, 4'd0, 1'b0);
      compare("blocked");
    end
    collide = 4'd0;
    wait_step("resume", g);
    push(212, 229, L, 4'd0, 1'b1);
    compare("resume");

    // Run left into the tunnel
    for (int x = 211; x >= 0; x--) begin
      wait_step("run_left", g);
      push(x, 229, L, 4'd0, 1'b1);
      compare("run_left");
    end
    wait_step("tunnel", g);
    push(447, 229, L, 4'd0, 1'b1);
    compare("tunnel_wrap");
    wait_step("after_tunnel", g);
    push(446, 229, L, 4'd0, 1'b1);
    compare("after_tunnel");

    // Run up to the top edge and saturate
    btn = U;
    tick();
    btn = 4'd0;
    for (int y = 228; y >= 0; y--) begin
      wait_step("run_up", g);
      push(446, y, U, 4'd0, 1'b1);
      compare("run_up");
    end
    for (int k = 0; k < 2; k++) begin
      wait_step("sat_top", g);
      push(446, 0, U, 4'd0, 1'b1);
      compare("sat_top");
    end

    // Request filtering: one-hot queues, multi-hot ignored, same-as-dir clears
    btn = R;
    tick();
    push(446, 0, U, R, 1'b1);
    compare("req_onehot");
    btn = 4'b0011;
    tick();
    push(446, 0, U, R, 1'b1);
    compare("req_multihot");
    btn = U;
    tick();
    btn = 4'd0;
    push(446, 0, U, 4'd0, 1'b1);
    compare("req_same_dir");
    wait_step("sat_after", g);
    push(446, 0, U, 4'd0, 1'b1);
    compare("sat_after");

    // Reset in the middle of a step period
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(200, 230, 4'd0, 4'd0, 1'b0);
    compare("mid_reset");
    check_eq("mid_reset_step", int'(step), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
